ioctl_dn_bridge: RTL

- Upstream stage of the input-test system: converts the HPS-style ioctl download stream into the paced dn_addr/dn_data/dn_wr/dn_index write bus that loads system ROM/RAM.
- Buffers bytes in a small FIFO and throttles the host with ioctl_wait.
- Enforces a minimum gap between downstream write strobes.
- Drives dn_busy, which holds the system in reset for the whole load session.

---
 rtl/ioctl_pkg.sv | 18 +
 rtl/dn_sync_fifo.sv | 53 +++++
 rtl/ioctl_dn_bridge.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ioctl_pkg.sv
// Shared types for the ioctl download bridge: FSM states, FIFO entry layout, host address width.
package ioctl_pkg;
    localparam int IOCTL_ADDR_W = 25;
    localparam int DN_ADDR_W    = 14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } dn_state_e;

    // Entry layout at the default downstream address width.
    typedef struct packed {
        logic [DN_ADDR_W-1:0] addr;
        logic [7:0]           data;
    } dn_ent_t;
endpackage

// File: rtl/dn_sync_fifo.sv
// Small synchronous FIFO with registered count; next-state count is exported so a
// downstream flag can be registered from it without an extra cycle of lag.
module dn_sync_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    cnt_next
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Push into a full FIFO with a same-cycle pop overwrites the slot being read out this cycle.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign cnt_next = cnt_d;
endmodule

// File: rtl/ioctl_dn_bridge.sv
// Converts the host ioctl byte stream into a paced downstream write bus, holding the
// system in reset (dn_busy) for the whole load session.
module ioctl_dn_bridge
    import ioctl_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int DEPTH       = 8,
    parameter int WAIT_THRESH = DEPTH - 2,
    parameter int WR_GAP      = 1
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    ioctl_download,
    input  logic                    ioctl_wr,
    input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]              ioctl_dout,
    input  logic [7:0]              ioctl_index,
    output logic                    ioctl_wait,
    output logic [ADDR_W-1:0]       dn_addr,
    output logic [7:0]              dn_data,
    output logic                    dn_wr,
    output logic [7:0]              dn_index,
    output logic                    dn_busy,
    output logic                    dn_done,
    output logic                    ovf_err,
    output logic                    rng_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (WR_GAP < 1) ? 1 : $clog2(WR_GAP + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } ent_t;

    dn_state_e         state_q, state_d;
    logic              dl_q, pend_q, pend_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              wait_q, wait_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        index_q, index_d;
    logic              ovf_q, ovf_d;
    logic              rng_q, rng_d;

    logic              fifo_empty, fifo_full, push, pop, host_wr, in_rng, rise;
    logic [CW-1:0]     cnt_next;
    ent_t              head, push_ent;

    assign rise     = ioctl_download && !dl_q;
    assign host_wr  = ioctl_download && ioctl_wr && (state_q == S_LOAD);
    assign in_rng   = (ioctl_addr[IOCTL_ADDR_W-1:ADDR_W] == '0);
    assign pop      = !fifo_empty && (gap_q == '0) && (state_q == S_LOAD || state_q == S_DRAIN);
    assign push     = host_wr && in_rng && (!fifo_full || pop);
    assign push_ent = '{addr: ioctl_addr[ADDR_W-1:0], data: ioctl_dout};

    dn_sync_fifo #(.WIDTH($bits(ent_t)), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk_sys),
        .rst      (reset),
        .push     (push),
        .wr_data  (push_ent),
        .pop      (pop),
        .rd_data  (head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .cnt_next (cnt_next)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        gap_d   = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        index_d = index_q;
        ovf_d   = ovf_q | (host_wr && in_rng && fifo_full && !pop);
        rng_d   = rng_q | (host_wr && !in_rng);

        if (pop) begin
            wr_d   = 1'b1;
            addr_d = head.addr;
            data_d = head.data;
            gap_d  = GW'(WR_GAP);
        end

        unique case (state_q)
            S_IDLE: begin
                if (rise || pend_q) begin
                    state_d = S_LOAD;
                    pend_d  = 1'b0;
                    index_d = ioctl_index;
                    ovf_d   = 1'b0;
                    rng_d   = 1'b0;
                end
            end
            // Level test: also leaves LOAD if the host dropped download again while a restart was pending.
            S_LOAD: if (!ioctl_download) state_d = S_DRAIN;
            S_DRAIN: begin
                if (rise) pend_d = 1'b1;
                if (fifo_empty && gap_q == '0 && !wr_q) state_d = S_DONE;
            end
            S_DONE: begin
                if (rise) pend_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        wait_d = (cnt_next >= CW'(WAIT_THRESH)) || state_d == S_DRAIN || state_d == S_DONE;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dl_q    <= 1'b0;
            pend_q  <= 1'b0;
            gap_q   <= '0;
            wait_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            index_q <= '0;
            ovf_q   <= 1'b0;
            rng_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dl_q    <= ioctl_download;
            pend_q  <= pend_d;
            gap_q   <= gap_d;
            wait_q  <= wait_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            index_q <= index_d;
            ovf_q   <= ovf_d;
            rng_q   <= rng_d;
        end
    end

    assign ioctl_wait = wait_q;
    assign dn_addr    = addr_q;
    assign dn_data    = data_q;
    assign dn_wr      = wr_q;
    assign dn_index   = index_q;
    assign dn_busy    = (state_q != S_IDLE);
    assign dn_done    = (state_q == S_DONE);
    assign ovf_err    = ovf_q;
    assign rng_err    = rng_q;
endmodule
